// File: rtl/code_mem_loader.sv
`default_nettype none
// ============================================================================
// code_mem_loader: framed byte-stream loader for the CPU code memory.
// Rev 1.0 - initial release
// ============================================================================
module code_mem_loader #(
  parameter int          DATA_WIDTH = 16,
  parameter int          ADDR_WIDTH = 8,
  parameter int          TIMEOUT    = 1000000,
  parameter logic [7:0]  SYNC       = 8'hA5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr_w,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  mem_we,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  load_done,
  output logic                  load_error
);

  localparam int          IW    = ADDR_WIDTH + 1;
  localparam int          TW    = $clog2(TIMEOUT + 1);
  localparam logic [16:0] DEPTH = 17'(1) << ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LEN_LO  = 3'd1,
    S_LEN_HI  = 3'd2,
    S_DATA_LO = 3'd3,
    S_DATA_HI = 3'd4,
    S_CSUM    = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [7:0]            len_lo_q, len_lo_d;
  logic [16:0]           len_q, len_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [7:0]            lo_q, lo_d;
  logic [7:0]            csum_q, csum_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  in_ready_q, in_ready_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
  logic                  cpu_reset_q, cpu_reset_d;
  logic                  busy_q, busy_d;
  logic                  load_done_q, load_done_d;
  logic                  load_error_q, load_error_d;

  logic                  accept;
  logic [16:0]           len_ext;
  logic [IW-1:0]         idx_inc;
  logic [TW-1:0]         tmo_inc;

  always_comb begin
    state_d      = state_q;
    len_lo_d     = len_lo_q;
    len_d        = len_q;
    idx_d        = idx_q;
    lo_d         = lo_q;
    csum_d       = csum_q;
    tmo_d        = tmo_q;
    in_ready_d   = 1'b1;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    cpu_reset_d  = cpu_reset_q;
    load_done_d  = 1'b0;
    load_error_d = load_error_q;

    accept  = in_valid && in_ready_q;
    len_ext = {1'b0, in_data, len_lo_q};
    idx_inc = idx_q + IW'(1);
    tmo_inc = tmo_q + TW'(1);

    if (state_q != S_IDLE) begin
      tmo_d = accept ? '0 : tmo_inc;
    end

    case (state_q)
      S_IDLE: begin
        tmo_d = '0;
        if (accept && in_data == SYNC) begin
          state_d      = S_LEN_LO;
          cpu_reset_d  = 1'b1;
          load_error_d = 1'b0;
          idx_d        = '0;
          csum_d       = '0;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          len_lo_d = in_data;
          state_d  = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          len_d = len_ext;
          if (len_ext > DEPTH) begin
            load_error_d = 1'b1;
            state_d      = S_IDLE;
          end else if (len_ext == 17'd0) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_DATA_LO;
          end
        end
      end
      S_DATA_LO: begin
        if (accept) begin
          lo_d    = in_data;
          csum_d  = csum_q + in_data;
          state_d = S_DATA_HI;
        end
      end
      S_DATA_HI: begin
        if (accept) begin
          mem_we_d   = 1'b1;
          mem_addr_d = idx_q[ADDR_WIDTH-1:0];
          mem_data_d = DATA_WIDTH'({in_data, lo_q});
          csum_d     = csum_q + in_data;
          idx_d      = idx_inc;
          state_d    = (17'(idx_inc) == len_q) ? S_CSUM : S_DATA_LO;
        end
      end
      S_CSUM: begin
        if (accept) begin
          if (in_data == csum_q) begin
            load_done_d = 1'b1;
            cpu_reset_d = 1'b0;
          end else begin
            load_error_d = 1'b1;
          end
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Inter-byte silence aborts the frame; CPU stays held in reset.
    if (state_q != S_IDLE && !accept && tmo_inc == TW'(TIMEOUT)) begin
      state_d      = S_IDLE;
      load_error_d = 1'b1;
      tmo_d        = '0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      len_lo_q     <= '0;
      len_q        <= '0;
      idx_q        <= '0;
      lo_q         <= '0;
      csum_q       <= '0;
      tmo_q        <= '0;
      in_ready_q   <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      cpu_reset_q  <= 1'b0;
      busy_q       <= 1'b0;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_lo_q     <= len_lo_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      lo_q         <= lo_d;
      csum_q       <= csum_d;
      tmo_q        <= tmo_d;
      in_ready_q   <= in_ready_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      cpu_reset_q  <= cpu_reset_d;
      busy_q       <= busy_d;
      load_done_q  <= load_done_d;
      load_error_q <= load_error_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign mem_we      = mem_we_q;
  assign mem_addr_w  = mem_addr_q;
  assign mem_data_in = mem_data_q;
  assign cpu_reset   = cpu_reset_q;
  assign busy        = busy_q;
  assign load_done   = load_done_q;
  assign load_error  = load_error_q;

endmodule
`default_nettype wire

// File: tb/tb_code_mem_loader.sv
`default_nettype none
// ============================================================================
// tb_code_mem_loader: directed self-checking bench for code_mem_loader.
// Rev 1.0 - initial release
// ============================================================================
module tb_code_mem_loader;

  localparam int TMO = 20;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  mem_addr_w;
  logic [15:0] mem_data_in;
  logic        mem_we;
  logic        cpu_reset;
  logic        busy;
  logic        load_done;
  logic        load_error;

  code_mem_loader #(
    .DATA_WIDTH (16),
    .ADDR_WIDTH (8),
    .TIMEOUT    (TMO),
    .SYNC       (8'hA5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .mem_addr_w  (mem_addr_w),
    .mem_data_in (mem_data_in),
    .mem_we      (mem_we),
    .cpu_reset   (cpu_reset),
    .busy        (busy),
    .load_done   (load_done),
    .load_error  (load_error)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  logic [15:0] mem [256];
  int          wr_count = 0;
  int          done_count = 0;
  logic [7:0]  last_addr = 8'h00;

  // Code-memory model fed from the write port.
  always @(negedge clk) begin
    if (mem_we) begin
      mem[mem_addr_w] = mem_data_in;
      wr_count++;
      last_addr = mem_addr_w;
    end
    if (load_done) done_count++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Byte is presented for one cycle; on return the DUT outputs reflect it.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int         w0, d0;
  logic [7:0] sum;

  initial begin
    // Reset state
    @(posedge clk); #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_addr", mem_addr_w, 0);
    check("rst_data", mem_data_in, 0);
    check("rst_cpu_reset", cpu_reset, 0);
    check("rst_busy", busy, 0);
    check("rst_done", load_done, 0);
    check("rst_error", load_error, 0);
    @(negedge clk); reset = 1'b0;
    idle(1);
    check("ready_after_rst", in_ready, 1);

    // Basic two-word load
    w0 = wr_count; d0 = done_count;
    send(8'hA5);
    check("f1_cpu_reset_set", cpu_reset, 1);
    check("f1_busy", busy, 1);
    send(8'h02); send(8'h00); send(8'h11); send(8'h20);
    check("f1_we_pulse", mem_we, 1);
    check("f1_addr0", mem_addr_w, 0);
    check("f1_data0", mem_data_in, 16'h2011);
    send(8'hB1);
    check("f1_we_gap", mem_we, 0);
    send(8'h03); send(8'hE5);
    check("f1_done_pulse", load_done, 1);
    check("f1_cpu_released", cpu_reset, 0);
    idle(2);
    check("f1_mem0", mem[0], 16'h2011);
    check("f1_mem1", mem[1], 16'h03B1);
    check("f1_writes", wr_count - w0, 2);
    check("f1_dones", done_count - d0, 1);
    check("f1_error", load_error, 0);
    check("f1_busy_end", busy, 0);

    // Bad checksum then recovery
    w0 = wr_count; d0 = done_count;
    send(8'hA5); send(8'h02); send(8'h00); send(8'h11);
    send(8'h20); send(8'hB1); send(8'h03); send(8'hE4);
    idle(2);
    check("f2_error", load_error, 1);
    check("f2_cpu_held", cpu_reset, 1);
    check("f2_writes", wr_count - w0, 2);
    check("f2_no_done", done_count - d0, 0);
    send(8'hA5);
    check("f2b_err_cleared", load_error, 0);
    send(8'h01); send(8'h00); send(8'h34); send(8'h12); send(8'h46);
    idle(1);
    check("f2b_cpu_released", cpu_reset, 0);
    check("f2b_mem0", mem[0], 16'h1234);

    // Junk before SYNC, zero-length frame
    w0 = wr_count; d0 = done_count;
    send(8'h00); send(8'hFF);
    check("junk_ignored", busy, 0);
    send(8'hA5); send(8'h00); send(8'h00); send(8'h00);
    idle(2);
    check("f3_no_writes", wr_count - w0, 0);
    check("f3_done", done_count - d0, 1);
    check("f3_cpu_released", cpu_reset, 0);

    // Oversize length
    w0 = wr_count;
    send(8'hA5); send(8'h01); send(8'h01);
    check("f4_error", load_error, 1);
    check("f4_idle", busy, 0);
    idle(2);
    check("f4_no_writes", wr_count - w0, 0);
    check("f4_cpu_held", cpu_reset, 1);

    // Full-depth frame
    w0 = wr_count; d0 = done_count; sum = 8'h00;
    send(8'hA5); send(8'h00); send(8'h01);
    for (int i = 0; i < 256; i++) begin
      send(8'(i));
      send(8'(i) ^ 8'h3C);
      sum = sum + 8'(i) + (8'(i) ^ 8'h3C);
    end
    send(sum);
    idle(2);
    check("f5_writes", wr_count - w0, 256);
    check("f5_last_addr", last_addr, 8'hFF);
    check("f5_mem0", mem[0], 16'h3C00);
    check("f5_mem255", mem[255], 16'hC3FF);
    check("f5_done", done_count - d0, 1);
    check("f5_error", load_error, 0);

    // Inter-byte timeout
    w0 = wr_count;
    send(8'hA5); send(8'h01); send(8'h00); send(8'h11);
    idle(TMO - 1);
    check("tmo_not_yet", load_error, 0);
    check("tmo_busy", busy, 1);
    idle(1);
    check("tmo_error", load_error, 1);
    check("tmo_idle", busy, 0);
    check("tmo_cpu_held", cpu_reset, 1);
    check("tmo_no_writes", wr_count - w0, 0);

    // Reset mid-frame
    send(8'hA5); send(8'h03); send(8'h00); send(8'h12); send(8'h34);
    check("mid_we", mem_we, 1);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_we", mem_we, 0);
    check("mid_rst_cpu", cpu_reset, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_error", load_error, 0);
    check("mid_rst_ready", in_ready, 0);
    check("mid_rst_addr", mem_addr_w, 0);
    @(negedge clk); reset = 1'b0;
    d0 = done_count;
    send(8'hA5); send(8'h01); send(8'h00); send(8'hCD); send(8'hAB); send(8'h78);
    idle(2);
    check("post_rst_mem0", mem[0], 16'hABCD);
    check("post_rst_done", done_count - d0, 1);
    check("post_rst_cpu", cpu_reset, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/code_mem_loader.md
# code_mem_loader

Byte-stream program loader that writes the write port of the CPU code memory (`addr_w`/`data_in`/`we`). It accepts a framed image from an upstream byte source (UART receiver or host bridge), assembles 16-bit little-endian instruction words, and writes them to consecutive code addresses starting at 0. It holds the CPU in reset for the whole load and reports completion or error.

## Interface
- `DATA_WIDTH`, 16: code word width; fixed at 16 (two bytes per word).
- `ADDR_WIDTH`, 8: code memory address width; depth = 2^ADDR_WIDTH words.
- `TIMEOUT`, 1000000: idle cycles allowed between bytes inside a frame.
- `SYNC`, 8'hA5: frame start byte.

Ports:
- `clk`  in  1  sole clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_data`  in  8  received byte.
- `in_valid`  in  1  byte strobe; one byte per cycle with `in_valid`=1.
- `in_ready`  out  1  loader can accept a byte.
- `mem_addr_w`  out  ADDR_WIDTH  code memory write address.
- `mem_data_in`  out  DATA_WIDTH  code memory write data.
- `mem_we`  out  1  code memory write enable, one-cycle pulse per word.
- `cpu_reset`  out  1  holds the CPU in reset.
- `busy`  out  1  frame in progress (state != IDLE).
- `load_done`  out  1  one-cycle pulse on successful load.
- `load_error`  out  1  sticky error flag.

## Operation
- Frame: `SYNC`, `LEN_LO`, `LEN_HI`, N words as (lo byte, hi byte), `CSUM`. N = {LEN_HI, LEN_LO}.
- CSUM = 8-bit sum mod 256 of the 2N data bytes only. Header bytes are excluded.
- Byte accepted = `in_valid` && `in_ready`. `in_ready` = 1 in every state after reset.
- States: IDLE, LEN_LO, LEN_HI, DATA_LO, DATA_HI, CSUM.
- IDLE: `SYNC` -> LEN_LO.
  - On this transition: `cpu_reset`<=1, `load_error`<=0, word index and checksum cleared.
  - Other bytes are ignored.
- LEN_LO -> LEN_HI.
- LEN_HI:
  - N > 2^ADDR_WIDTH -> `load_error`<=1, go to IDLE. No writes occur.
  - N = 0 -> CSUM.
  - Otherwise -> DATA_LO.
- DATA_LO: latch the byte -> DATA_HI.
- DATA_HI: issue the write.
  - `mem_data_in`={hi,lo}, `mem_addr_w`=word index, `mem_we`=1.
  - Then index+1. If index+1 = N -> CSUM, else -> DATA_LO.
- CSUM: byte == running sum -> `load_done` pulse, `cpu_reset`<=0. Otherwise `load_error`<=1 and `cpu_reset` stays 1. Both outcomes -> IDLE.
- No resync inside a frame: a `SYNC` value received in a non-IDLE state is treated as ordinary data.
- Timeout:
  - Counter clears on every accepted byte and increments each cycle in a non-IDLE state.
  - Reaching `TIMEOUT` -> `load_error`<=1, go to IDLE, `cpu_reset` stays 1.
- After an error, `cpu_reset` stays 1 until a later frame completes successfully or `reset` is asserted.
- Index width is ADDR_WIDTH+1, so N = 2^ADDR_WIDTH completes without wrapping.

## Timing
- Reset values: state IDLE, `in_ready`=0 during the reset cycle, then 1. `mem_we`=0, `mem_addr_w`=0, `mem_data_in`=0, `cpu_reset`=0, `busy`=0, `load_done`=0, `load_error`=0.
- All outputs are registered.
- `mem_we` is high exactly in the cycle after the DATA_HI byte is accepted. Address and data are valid in that same cycle.
- `load_done` and the `cpu_reset` fall occur in the cycle after the CSUM byte is accepted. `load_error` rises in the cycle after the offending byte, or after the timeout cycle.
- Back-to-back bytes on consecutive cycles are supported. The writes are then at most one per two cycles.
- `reset` mid-frame: return to IDLE next cycle and release `cpu_reset`. Memory contents already written are left as they are.

## Test plan
- Bytes A5,02,00,11,20,B1,03,E5 -> writes addr0=0x2011, addr1=0x03B1. `load_done` pulses once, `cpu_reset` 1->0, `load_error`=0.
- Same frame with CSUM=E4 -> both writes occur, `load_error`=1, `cpu_reset` remains 1, no `load_done`. Then a correct frame -> `load_error` cleared at its SYNC and `cpu_reset`=0 at its end.
- A5,00,00,00 -> no `mem_we`, `load_done` pulses. Bytes 00,FF before the A5 are ignored.
- A5,01,01 with ADDR_WIDTH=8 (N=257) -> `load_error`=1, IDLE, zero writes. N=256 with a correct checksum -> 256 writes, last address 0xFF.
- A5,01,00,11 then silence for `TIMEOUT` cycles -> `load_error`=1, state IDLE, no `mem_we`, `cpu_reset`=1.
- `reset` asserted after the first written word of a 3-word frame -> all outputs at reset values next cycle. A following full frame loads correctly.
